llpm_route_buffered: RTL and testbench

Buffered 1-to-N steering vertex: the splitting counterpart of the LLPM select vertices. It accepts one token stream carrying a destination index and delivers each token to exactly one of NumOutputs output channels. Each output has a 2-entry FIFO, so one blocked output never stalls traffic bound for the others. Output-side valid and data are fully registered. It sits wherever the compiler fans a single producer out to several consumers by an explicit route field.

---
 rtl/llpm_route_buffered_if.sv | 26 ++
 rtl/llpm_route_buffered.sv | 77 +++++++
 tb/tb_llpm_route_buffered.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/llpm_route_buffered_if.sv
// Token bundle for llpm_route_buffered: one routed input stream and
// NumOutputs buffered output channels.
interface llpm_route_buffered_if #(
  parameter int Width           = 8,
  parameter int NumOutputs      = 4,
  parameter int CLog2NumOutputs = 2
);
  logic [Width-1:0]                  x;
  logic [CLog2NumOutputs-1:0]        x_sel;
  logic                              x_valid;
  logic                              x_bp;
  logic [NumOutputs-1:0][Width-1:0]  a;
  logic [NumOutputs-1:0]             a_valid;
  logic [NumOutputs-1:0]             a_bp;
  logic                              drop;

  modport master (
    output x, x_sel, x_valid, a_bp,
    input  x_bp, a, a_valid, drop
  );

  modport slave (
    input  x, x_sel, x_valid, a_bp,
    output x_bp, a, a_valid, drop
  );
endinterface

// File: rtl/llpm_route_buffered.sv
// Buffered 1-to-N steering vertex: each token goes to the output named by
// x_sel through a private 2-entry FIFO; out-of-range tokens are discarded.
module llpm_route_buffered #(
  parameter int Width           = 8,
  parameter int NumOutputs      = 4,
  parameter int CLog2NumOutputs = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  llpm_route_buffered_if.slave  bus
);

  logic [NumOutputs-1:0] sel_hit;
  logic [NumOutputs-1:0] full;
  logic [NumOutputs-1:0] push;
  logic                  accept;
  logic                  drop_q;

  // Backpressure looks only at registered counts, never at any a_bp.
  assign bus.x_bp = |(full & sel_hit);
  assign accept   = bus.x_valid & ~bus.x_bp;
  assign push     = sel_hit & {NumOutputs{accept}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      drop_q <= accept & ~|sel_hit;
    end
  end

  assign bus.drop = drop_q;

  for (genvar k = 0; k < NumOutputs; k++) begin : g_fifo
    logic [Width-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             pop;

    assign sel_hit[k] = (int'(bus.x_sel) == k);
    assign pop        = (count != 2'd0) && !bus.a_bp[k];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        // NOTE: the storage is reset too, so the head seen while empty is
        // deterministic and X-free rather than whatever powered up.
        mem[0] <= '0;
        mem[1] <= '0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push[k]) begin
          mem[wr_ptr] <= bus.x;
          wr_ptr      <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        // Push and pop together leave the count unchanged.
        case ({push[k], pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end

    assign full[k]        = (count == 2'd2);
    assign bus.a_valid[k] = (count != 2'd0);
    assign bus.a[k]       = mem[rd_ptr];
  end

endmodule

// File: tb/tb_llpm_route_buffered.sv
// Scoreboard bench for llpm_route_buffered: directed stimulus pushes expected
// tokens per output; a monitor pops and compares on every output transfer.
module tb_llpm_route_buffered;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   failures = 0;

  typedef struct {
    logic [7:0] data;
    int         acc;
    bit         exact;
  } sb_t;

  sb_t exp_q [4][$];

  llpm_route_buffered_if #(.Width(8), .NumOutputs(4), .CLog2NumOutputs(2)) b ();
  llpm_route_buffered_if #(.Width(8), .NumOutputs(3), .CLog2NumOutputs(2)) b3 ();

  llpm_route_buffered #(.Width(8), .NumOutputs(4), .CLog2NumOutputs(2)) u_dut (
    .clk   (clk),
    .reset (rst),
    .bus   (b)
  );

  llpm_route_buffered #(.Width(8), .NumOutputs(3), .CLog2NumOutputs(2)) u_dut3 (
    .clk   (clk),
    .reset (rst),
    .bus   (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one token starting just after a rising edge; returns just after
  // the edge on which it was (or was not) accepted.
  task automatic send(input logic [7:0] d, input logic [1:0] s, input bit exp_bp, input bit exact);
    sb_t e;
    b.x       = d;
    b.x_sel   = s;
    b.x_valid = 1'b1;
    @(negedge clk);
    check($sformatf("x_bp_sel%0d_x%02h", s, d), {31'd0, b.x_bp}, {31'd0, exp_bp});
    @(posedge clk); #1;
    if (!exp_bp) begin
      e = '{data: d, acc: cyc, exact: exact};
      exp_q[s].push_back(e);
    end
  endtask

  task automatic idle(input int n);
    b.x_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every output transfer must match the oldest expected token.
  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (b.a_valid[k] && !b.a_bp[k]) begin
          if (exp_q[k].size() == 0) begin
            tests++;
            failures++;
            $display("FAIL unexpected_out%0d: got token 0x%02h, expected none", k, b.a[k]);
          end else begin
            e = exp_q[k].pop_front();
            check($sformatf("data_out%0d", k), {24'd0, b.a[k]}, {24'd0, e.data});
            if (e.exact)
              check($sformatf("latency_out%0d", k), cyc, e.acc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    b.x = '0; b.x_sel = '0; b.x_valid = 1'b0; b.a_bp = '0;
    b3.x = '0; b3.x_sel = '0; b3.x_valid = 1'b0; b3.a_bp = '0;
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_a_valid", {28'd0, b.a_valid}, 32'd0);
    check("reset_x_bp", {31'd0, b.x_bp}, 32'd0);
    check("reset_drop", {31'd0, b.drop}, 32'd0);
    check("reset_a0", {24'd0, b.a[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single token to output 2, visible for exactly one cycle
    send(8'hA5, 2'd2, 1'b0, 1'b1);
    b.x_valid = 1'b0;
    @(negedge clk);
    check("t1_a_valid", {28'd0, b.a_valid}, 32'h4);
    check("t1_a2", {24'd0, b.a[2]}, 32'hA5);
    check("t1_x_bp", {31'd0, b.x_bp}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_gone", {28'd0, b.a_valid}, 32'd0);
    @(posedge clk); #1;

    // Blocked output 1 fills; output 0 still flows
    b.a_bp = 4'b0010;
    send(8'h01, 2'd1, 1'b0, 1'b0);
    send(8'h02, 2'd1, 1'b0, 1'b0);
    send(8'h03, 2'd1, 1'b1, 1'b0);
    send(8'h10, 2'd0, 1'b0, 1'b1);
    b.x_valid = 1'b0;
    @(negedge clk);
    check("t2_head1", {24'd0, b.a[1]}, 32'h01);
    check("t2_valid1", {31'd0, b.a_valid[1]}, 32'd1);
    @(posedge clk); #1;
    b.a_bp = 4'b0000;
    idle(1);
    send(8'h03, 2'd1, 1'b0, 1'b0);
    idle(3);

    // Round-robin stream, full rate, no backpressure
    for (int i = 0; i < 8; i++)
      send(8'(i), 2'(i % 4), 1'b0, 1'b1);
    idle(2);

    // Reset mid-operation with output 0 full
    b.a_bp = 4'b0001;
    send(8'hE1, 2'd0, 1'b0, 1'b0);
    send(8'hE2, 2'd0, 1'b0, 1'b0);
    b.x_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midreset_a_valid", {28'd0, b.a_valid}, 32'd0);
    check("midreset_x_bp", {31'd0, b.x_bp}, 32'd0);
    exp_q[0].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    b.a_bp = 4'b0000;
    @(posedge clk); #1;
    send(8'h55, 2'd0, 1'b0, 1'b1);
    b.x_valid = 1'b0;
    @(negedge clk);
    check("post_reset_valid", {28'd0, b.a_valid}, 32'h1);
    check("post_reset_a0", {24'd0, b.a[0]}, 32'h55);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_reset_alone", {28'd0, b.a_valid}, 32'd0);
    @(posedge clk); #1;

    // Output 3 at count 1: pop and push on the same edge
    b.a_bp = 4'b1000;
    send(8'h66, 2'd3, 1'b0, 1'b0);
    idle(1);
    b.a_bp = 4'b0000;
    send(8'h77, 2'd3, 1'b0, 1'b1);
    b.x_valid = 1'b0;
    @(negedge clk);
    check("t6_valid3", {31'd0, b.a_valid[3]}, 32'd1);
    check("t6_head3", {24'd0, b.a[3]}, 32'h77);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_empty3", {31'd0, b.a_valid[3]}, 32'd0);
    @(posedge clk); #1;

    // Out-of-range destination on the 3-output instance, two back-to-back
    b3.x = 8'hFF; b3.x_sel = 2'd3; b3.x_valid = 1'b1;
    @(negedge clk);
    check("drop_x_bp", {31'd0, b3.x_bp}, 32'd0);
    check("drop_before", {31'd0, b3.drop}, 32'd0);
    @(posedge clk); #1;
    b3.x = 8'hEE;
    @(negedge clk);
    check("drop_first", {31'd0, b3.drop}, 32'd1);
    check("drop_no_valid", {29'd0, b3.a_valid}, 32'd0);
    @(posedge clk); #1;
    b3.x_valid = 1'b0;
    @(negedge clk);
    check("drop_second", {31'd0, b3.drop}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("drop_clear", {31'd0, b3.drop}, 32'd0);
    check("drop_no_valid_end", {29'd0, b3.a_valid}, 32'd0);
    @(posedge clk); #1;

    check("sb_drained", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
